// File: rtl/text_readback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_readback: bus initiator that reads the text character buffer back     |
// | and streams each character while folding it into a 16-bit signature.      |
// | Optional: TEXT_READBACK_TIMEOUT_EN enables a per-read wait timeout.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module text_readback #(
  parameter logic [63:0] BASE_ADDR = 64'h30002,
  parameter int          CELLS     = 7200,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] address,
  output logic        read,
  output logic        write,
  input  logic [63:0] read_data,
  input  logic        read_valid,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  char_out,
  output logic        char_valid,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [13:0] c_LAST = 14'(CELLS - 1);

  state_t      r_state;
  logic [13:0] r_count;
  logic [13:0] w_count_next;
  logic [15:0] w_sig_next;

  assign w_count_next = r_count + 14'd1;
  // Rotate-left-by-one then add: order-sensitive, so swapped cells are caught.
  assign w_sig_next   = {checksum[14:0], checksum[15]} + {8'd0, read_data[7:0]};
  assign write        = 1'b0;

  logic w_unused_data;
  assign w_unused_data = ^read_data[63:8];

`ifdef TEXT_READBACK_TIMEOUT_EN
  logic [31:0] r_wait;
  logic [31:0] w_wait_next;
  assign w_wait_next = r_wait + 32'd1;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |32'(TIMEOUT);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= 14'd0;
      address    <= 64'd0;
      read       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      char_out   <= 8'd0;
      char_valid <= 1'b0;
      checksum   <= 16'd0;
`ifdef TEXT_READBACK_TIMEOUT_EN
      r_wait     <= 32'd0;
`endif
    end else begin
      read       <= 1'b0;
      done       <= 1'b0;
      char_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count  <= 14'd0;
            checksum <= 16'd0;
            error    <= 1'b0;
            char_out <= 8'd0;
            busy     <= 1'b1;
            read     <= 1'b1;
            address  <= BASE_ADDR;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
`ifdef TEXT_READBACK_TIMEOUT_EN
          r_wait  <= 32'd0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (read_valid) begin
            char_out   <= read_data[7:0];
            char_valid <= 1'b1;
            checksum   <= w_sig_next;
            if (r_count == c_LAST) begin
              r_state <= S_FIN;
            end else begin
              // Next request issues straight from WAIT so zero-wait reads pulse every other cycle.
              r_count <= w_count_next;
              address <= BASE_ADDR + {50'd0, w_count_next};
              read    <= 1'b1;
              r_state <= S_REQ;
            end
          end
`ifdef TEXT_READBACK_TIMEOUT_EN
          else if (w_wait_next >= 32'(TIMEOUT)) begin
            error   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_wait <= w_wait_next;
          end
`endif
        end
        S_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/text_readback.md
# text_readback

Bus initiator that reads the text-mode character buffer back over the same 64-bit `address`/`data`/`read`/`write` peripheral bus that writers use to fill it.
- On a `start` pulse it walks the character region from `BASE_ADDR` for `CELLS` consecutive addresses, issuing one read per cell.
- Each returned character is streamed out and folded into a 16-bit signature.
- It sits beside the VGA text peripheral and gives hardware self-test, with readback verified against a known screen image.

## Interface
Parameters:
- `BASE_ADDR`, default 64'h30002: address of cell 0.
- `CELLS`, default 7200: number of cells read per pass (legal range 1..16383).
- `TIMEOUT`, default 255: maximum wait cycles per read; used only with the macro below.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin a pass.
- `address` out 64: bus address.
- `read` out 1: one-cycle read strobe.
- `write` out 1: always 0.
- `read_data` in 64: responder return data; bits [7:0] are the character.
- `read_valid` in 1: responder marks `read_data` valid.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at end of pass.
- `error` out 1: sticky timeout flag.
- `char_out` out 8: last character received.
- `char_valid` out 1: one-cycle pulse, `char_out` updated.
- `checksum` out 16: running signature.

## Operation
- States: IDLE, REQ, WAIT, FIN.
- IDLE:
  - `start`=1 moves to REQ.
  - Clears `count` (14-bit), `checksum` and `error`.
  - Sets `busy`.
- REQ:
  - Drives `address` = `BASE_ADDR` + zero-extended `count` (64-bit add, wraps modulo 2^64).
  - Drives `read`=1 for exactly this cycle, then moves to WAIT.
- WAIT:
  - `read`=0; `address` is held.
  - On `read_valid`=1:
    - `char_out` <= `read_data[7:0]` and `char_valid`=1 for one cycle.
    - `checksum` <= {`checksum[14:0]`, `checksum[15]`} + {8'd0, char}, modulo 2^16.
  - Then, if `count` == `CELLS`-1, go to FIN; otherwise `count`+1 and go to REQ.
- FIN:
  - `done`=1 for one cycle and `busy`=0 on exit, returning to IDLE.
  - `checksum`, `char_out` and `error` hold until the next accepted `start`.
- Boundary rules:
  - `start` while `busy` is ignored.
  - `read_valid` outside WAIT is ignored, including in the same cycle as `read`.
  - `read_data` bits [63:8] are ignored.
- Reset, asynchronous at any point including mid-pass:
  - State returns to IDLE.
  - All outputs go to 0 (`address`=0, `read`=0, `write`=0, `busy`=0, `done`=0, `error`=0, `char_out`=0, `char_valid`=0, `checksum`=0).
  - No partial pass resumes.

## Timing
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled; REQ is that same cycle, so `read` and `busy` rise together.
- The earliest `read_valid` is accepted one cycle after `read`, giving a minimum of 2 cycles per cell.
- Minimum pass: `start` sampled at cycle 0, last `char_valid` at cycle 2·`CELLS`, `done` at cycle 2·`CELLS`+1.
- `checksum` reflects a character the same cycle `char_valid` is high.
- With zero responder wait, `read` pulses every second cycle.

## Configuration
- `TEXT_READBACK_TIMEOUT_EN` defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without `read_valid`.
  - When it reaches `TIMEOUT`, `error` <= 1, the current cell is dropped (no `char_valid`, no checksum update) and the state goes to FIN.
- Not defined:
  - The counter is absent, `error` is tied to 0 and WAIT lasts indefinitely.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle. All outputs read 0 immediately and state is IDLE.
- Zero-wait responder, `CELLS`=3, memory holds 84, 73, 77:
  - Addresses 0x30002, 0x30003 and 0x30004 are read.
  - `char_out` sequence is 84, 73, 77 and final `checksum` = 0x022F.
  - `done` pulses at cycle 7.
- Variable latency, `CELLS`=3, 0/5/2 wait cycles: same characters and `checksum` 0x022F, with `read` never asserted while in WAIT.
- `start` pulsed during pass, plus stray `read_valid` during REQ: both ignored and the result is unchanged (0x022F).
- Reset mid-pass after 1 character, then new `start`: the pass restarts at 0x30002 and the checksum is again 0x022F.
- With the macro and `TIMEOUT`=4, the responder never answers cell 1: `error`=1 and `done` pulses 4 cycles into WAIT. `checksum`=84 and exactly one `char_valid` is seen. The next `start` clears `error`.
